data_mem_be: RTL and testbench
==============================

// Module: data_mem_be
// PURPOSE
//   Parametrised successor to the single-cycle data RAM. Word-organised RAM with
//   byte-lane writes, a registered read port, range/alignment error reporting and a
//   post-reset clear sequencer. Sits on the CPU load/store path behind the ALU
//   address output; the pipeline stalls on busy.
// PARAMETERS
//   DATA_W     32    word width in bits; multiple of 8
//   DEPTH      256   number of words
//   ADDR_W     32    byte-address width
//   BASE_ADDR  0     byte address of word 0
// PORTS
//   clk     in   1          clock, rising edge
//   reset   in   1          asynchronous, active-high reset
//   rd      in   1          read request, sampled at posedge
//   wr      in   1          write request, sampled at posedge
//   be      in   DATA_W/8   byte enables for writes; bit i -> wdata[8i+7:8i]
//   addr    in   ADDR_W     byte address
//   wdata   in   DATA_W     write data
//   rdata   out  DATA_W     read data, registered
//   rvalid  out  1          one-cycle pulse: rdata updated this cycle
//   busy    out  1          clear sequence in progress; requests ignored
//   err     out  1          one-cycle pulse: previous request out of range or misaligned
// BEHAVIOUR
//   - Reset (async assert): rdata=0, rvalid=0, err=0, busy=1, clear pointer=0,
//     FSM=CLEAR. Reset asserted mid-clear or mid-access restarts the clear from word 0.
//   - FSM CLEAR: each cycle writes 0 to word[ptr], then ptr++. After word DEPTH-1 is
//     written -> IDLE. busy=1 for exactly DEPTH cycles after reset deasserts.
//     In CLEAR, rd/wr are ignored: no write, no rvalid, no err.
//   - FSM IDLE: busy=0; remains in IDLE until reset.
//   - Decode: off=addr-BASE_ADDR (ADDR_W bits, unsigned); idx=off>>log2(DATA_W/8).
//     ok = (addr>=BASE_ADDR) && (idx<DEPTH) && (off low log2(DATA_W/8) bits == 0).
//   - Write (IDLE, wr, ok): at posedge, lanes with be[i]=1 are updated; others keep
//     their value. be=0 is a legal no-op. wr with !ok: no write; err=1 next cycle.
//   - Read (IDLE, rd): latency 1. rd at edge N -> rdata/rvalid valid after edge N+1.
//     ok: rdata=word[idx]. !ok: rdata=0 and err=1, rvalid=1.
//     When no read occurs, rdata holds its last value and rvalid=0.
//   - err: asserted for one cycle when either rd or wr in the previous cycle was !ok.
//     A single err covers both when rd and wr are both !ok.
//   - rd & wr in the same cycle to the same idx: see CONFIGURATION.
//     Different idx: the accesses are independent.
//   - Address wrap: addr<BASE_ADDR is out of range. No modulo aliasing of idx.
// CONFIGURATION
//   DATA_MEM_BYPASS_EN defined:
//     For a same-cycle rd+wr to the same valid idx, rdata returns the merged value:
//     new bytes where be=1, old bytes elsewhere (write-first).
//   DATA_MEM_BYPASS_EN undefined:
//     rdata returns the pre-write word (read-first).
// TESTING
//   1. Reset, then hold rd=0 -> busy=1 for exactly DEPTH cycles. Then read every
//      word -> all 0, rvalid pulses, err=0.
//   2. wr addr=0x10 wdata=0xAABBCCDD be=4'b1111, then wr be=4'b0101 wdata=0x11223344,
//      rd 0x10 -> rdata=0xAA22CC44 one cycle after rd.
//   3. rd addr=0x400 (DEPTH=256) -> rdata=0, rvalid=1, err=1. rd addr=0x12
//      (misaligned) -> err=1. wr addr=0x400 -> no write, err=1.
//   4. word 0x20=0x12345678; same-cycle rd+wr 0x20 wdata=0xFFFFFFFF be=4'b0011 ->
//      rdata=0x1234FFFF with DATA_MEM_BYPASS_EN; 0x12345678 without.
//   5. Assert reset at clear cycle 100. Release -> busy lasts a full DEPTH cycles again.
//      wr/rd during busy -> no effect, no rvalid, no err.
//   6. BASE_ADDR=0x1000, DATA_W=64 -> rd 0x0FF8 -> err=1. wr/rd 0x1008 round-trips
//      a 64-bit value.

Source files
------------

// File: rtl/data_mem_be_if.sv
// data_mem_be_if: load/store bus between the CPU pipeline and data_mem_be.
//   master (CPU side) drives rd, wr, be, addr, wdata and receives rdata,
//   rvalid, busy, err.
//   slave (memory side) is the mirror image.
//   Parameters DATA_W / ADDR_W must match the attached data_mem_be instance.
interface data_mem_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  rd;
  logic                  wr;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  busy;
  logic                  err;

  modport master (
    output rd, wr, be, addr, wdata,
    input  rdata, rvalid, busy, err
  );

  modport slave (
    input  rd, wr, be, addr, wdata,
    output rdata, rvalid, busy, err
  );
endinterface

// File: rtl/data_mem_be.sv
// data_mem_be: word-organised data RAM with byte-lane writes, registered read
// port, range/alignment error reporting and a post-reset clear sequencer.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    data_mem_be_if.slave:
//            rd/wr/be/addr/wdata  request, sampled at posedge
//            rdata                registered read data (holds when no read)
//            rvalid               one-cycle pulse, rdata updated
//            busy                 clear sequence running, requests ignored
//            err                  one-cycle pulse, previous request bad address
// Build option: DATA_MEM_BYPASS_EN selects write-first data for a same-cycle
// rd+wr to one word; without it the read returns the pre-write word.

// One byte lane of the write merge: new byte when enabled, else keep old.
module data_mem_be_lane (
  input  logic       be,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = be ? new_byte : old_byte;
endmodule

module data_mem_be #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         reset,
  data_mem_be_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int LG    = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << LG) - 64'd1);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // Address decode. off wraps when addr < BASE_ADDR, so the explicit
  // lower-bound test is what rejects those addresses (no aliasing).
  logic [ADDR_W-1:0] off, word_off;
  logic [IDX_W-1:0]  idx;
  logic              in_range, aligned, ok, idle;

  assign off      = bus.addr - BASE_ADDR;
  assign word_off = off >> LG;
  assign idx      = IDX_W'(word_off);
  assign in_range = (bus.addr >= BASE_ADDR) && (word_off < ADDR_W'(DEPTH));
  assign aligned  = (off & ALIGN_MASK) == '0;
  assign ok       = in_range && aligned;
  assign idle     = (state_q == S_IDLE);

  // Current word and its byte-merged update; the merge is both the stored
  // value on a write and the write-first read data.
  logic [NB-1:0][7:0] old_word, wdata_b, merged;

  assign old_word = mem[idx];
  assign wdata_b  = bus.wdata;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    data_mem_be_lane u_lane (
      .be       (bus.be[i]),
      .old_byte (old_word[i]),
      .new_byte (wdata_b[i]),
      .merged   (merged[i])
    );
  end

  logic do_wr;
  assign do_wr = idle && bus.wr && ok;

  // Clear sequencer and request handling.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        // rd and wr share one address, so one err covers both.
        err_d = (bus.rd || bus.wr) && !ok;
        if (bus.rd) begin
          rvalid_d = 1'b1;
          if (!ok) begin
            rdata_d = '0;
          end else begin
`ifdef DATA_MEM_BYPASS_EN
            rdata_d = bus.wr ? merged : old_word;
`else
            rdata_d = old_word;
`endif
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_CLEAR;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Storage has no reset; its contents are defined by the clear sequencer.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) mem[ptr_q] <= '0;
    else if (do_wr)         mem[idx]   <= merged;
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q == S_CLEAR);
endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: randomized + directed scoreboard bench for data_mem_be.
// Two instances: u_dut0 (32-bit, 256 words, base 0) and u_dut1 (64-bit,
// 16 words, base 0x1000). Requests are scored against a word-array model.
module tb_data_mem_be;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef DATA_MEM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  data_mem_be_if #(.DATA_W(32), .ADDR_W(32)) bus0();
  data_mem_be_if #(.DATA_W(64), .ADDR_W(32)) bus1();

  data_mem_be #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  data_mem_be #(.DATA_W(64), .DEPTH(16), .ADDR_W(32), .BASE_ADDR(32'h1000)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  typedef struct packed {
    logic        rv;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [63:0] mdl [2][256];
  int checks = 0;
  int errors = 0;
  bit tb_idle = 1'b0;
  logic [63:0] last0 = '0, last1 = '0;
  exp_t m0, m1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    bus0.rd = 1'b0; bus0.wr = 1'b0;
    bus1.rd = 1'b0; bus1.wr = 1'b0;
  endtask

  // Drive one request cycle and, if the memory is accepting requests, record
  // the expected response and update the model.
  task automatic req(input int sel, input logic r, input logic w, input logic [7:0] be,
                     input logic [31:0] a, input logic [63:0] wd);
    int nb, depth, idx;
    logic [31:0] base, off;
    logic ok;
    logic [63:0] old, mrg;
    exp_t e;
    nb    = (sel == 0) ? 4 : 8;
    depth = (sel == 0) ? 256 : 16;
    base  = (sel == 0) ? 32'h0 : 32'h1000;
    @(posedge clk); #1;
    bus0.rd = 1'b0; bus0.wr = 1'b0; bus1.rd = 1'b0; bus1.wr = 1'b0;
    if (sel == 0) begin
      bus0.rd = r; bus0.wr = w; bus0.be = be[3:0]; bus0.addr = a; bus0.wdata = wd[31:0];
    end else begin
      bus1.rd = r; bus1.wr = w; bus1.be = be; bus1.addr = a; bus1.wdata = wd;
    end
    if (tb_idle) begin
      off = a - base;
      ok  = (a >= base) && (off % 32'(nb) == 0) && (off / 32'(nb) < 32'(depth));
      idx = ok ? int'(off / 32'(nb)) : 0;
      old = mdl[sel][idx];
      mrg = old;
      for (int b = 0; b < nb; b++) if (be[b]) mrg[8*b +: 8] = wd[8*b +: 8];
      if (r) begin
        e.rv = 1'b1; e.err = !ok;
        e.rdata = !ok ? 64'h0 : ((w && BYPASS) ? mrg : old);
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
      end else if (w && !ok) begin
        e.rv = 1'b0; e.err = 1'b1; e.rdata = 64'h0;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (w && ok) mdl[sel][idx] = mrg;
    end
  endtask

  // Count busy cycles after reset release; both instances must clear.
  task automatic wait_clear();
    int c0 = 0, c1 = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (bus0.busy) c0++;
      if (bus1.busy) c1++;
      if (!bus0.busy && !bus1.busy) break;
    end
    chk("busy_cycles0", 64'(c0), 64'd256);
    chk("busy_cycles1", 64'(c1), 64'd16);
    for (int s = 0; s < 2; s++) for (int i = 0; i < 256; i++) mdl[s][i] = '0;
    tb_idle = 1'b1;
  endtask

  // Monitors: pop an expectation whenever the DUT presents rvalid or err.
  always @(negedge clk) begin
    if (reset) last0 = '0;
    else if (bus0.rvalid || bus0.err) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out0 rvalid=%0b err=%0b required=no output", bus0.rvalid, bus0.err);
      end else begin
        m0 = q0.pop_front();
        chk("rvalid0", 64'(bus0.rvalid), 64'(m0.rv));
        chk("err0", 64'(bus0.err), 64'(m0.err));
        if (m0.rv) begin
          chk("rdata0", 64'(bus0.rdata), m0.rdata);
          last0 = m0.rdata;
        end else chk("hold0", 64'(bus0.rdata), last0);
      end
    end else chk("hold0", 64'(bus0.rdata), last0);
  end

  always @(negedge clk) begin
    if (reset) last1 = '0;
    else if (bus1.rvalid || bus1.err) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out1 rvalid=%0b err=%0b required=no output", bus1.rvalid, bus1.err);
      end else begin
        m1 = q1.pop_front();
        chk("rvalid1", 64'(bus1.rvalid), 64'(m1.rv));
        chk("err1", 64'(bus1.err), 64'(m1.err));
        if (m1.rv) begin
          chk("rdata1", bus1.rdata, m1.rdata);
          last1 = m1.rdata;
        end else chk("hold1", bus1.rdata, last1);
      end
    end else chk("hold1", bus1.rdata, last1);
  end

  function automatic logic [31:0] rand_addr0();
    int k;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    w = 32'($urandom_range(0, 15)) + ((k == 0) ? 32'($urandom_range(0, 255)) : 32'h0);
    if (w > 255) w = 255;
    if (k < 7)       return w << 2;
    else if (k == 7) return (w << 2) + 32'($urandom_range(1, 3));
    else if (k == 8) return 32'h400 + (32'($urandom_range(0, 63)) << 2);
    else             return 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] rand_addr1();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)       return 32'h1000 + (32'($urandom_range(0, 15)) << 3);
    else if (k == 7) return 32'h1000 + (32'($urandom_range(0, 15)) << 3) + 32'($urandom_range(1, 7));
    else if (k == 8) return 32'h1080 + (32'($urandom_range(0, 7)) << 3);
    else             return 32'h0FF8 - (32'($urandom_range(0, 7)) << 3);
  endfunction

  initial begin
    reset = 1'b1;
    bus0.rd = 0; bus0.wr = 0; bus0.be = '0; bus0.addr = '0; bus0.wdata = '0;
    bus1.rd = 0; bus1.wr = 0; bus1.be = '0; bus1.addr = '0; bus1.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata0", 64'(bus0.rdata), 64'h0);
    chk("rst_rvalid0", 64'(bus0.rvalid), 64'h0);
    chk("rst_err0", 64'(bus0.err), 64'h0);
    chk("rst_busy0", 64'(bus0.busy), 64'h1);
    chk("rst_busy1", 64'(bus1.busy), 64'h1);
    @(posedge clk); #1 reset = 1'b0;
    wait_clear();

    // Reset mid-clear; requests while busy must be ignored.
    @(posedge clk); #1 reset = 1'b1; tb_idle = 1'b0;
    @(negedge clk);
    chk("rst2_busy0", 64'(bus0.busy), 64'h1);
    @(posedge clk); #1 reset = 1'b0;
    req(0, 1, 1, 8'hF, 32'h10, 64'hDEAD_BEEF);
    req(0, 1, 0, 8'h0, 32'h400, 64'h0);
    req(0, 0, 1, 8'hF, 32'h400, 64'h1);
    req(1, 1, 1, 8'hFF, 32'h1008, 64'h5555);
    idle_bus();
    repeat (94) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_clear();

    // Every word reads back zero after the clear.
    for (int i = 0; i < 256; i++) req(0, 1, 0, 8'h0, 32'(i) << 2, 64'h0);
    idle_bus();

    // Byte-lane merge.
    req(0, 0, 1, 8'hF, 32'h10, 64'hAABB_CCDD);
    req(0, 0, 1, 8'h5, 32'h10, 64'h1122_3344);
    req(0, 1, 0, 8'h0, 32'h10, 64'h0);
    idle_bus();

    // Range and alignment errors.
    req(0, 1, 0, 8'h0, 32'h400, 64'h0);
    req(0, 1, 0, 8'h0, 32'h12, 64'h0);
    req(0, 0, 1, 8'hF, 32'h400, 64'hFFFF_FFFF);
    req(0, 1, 1, 8'hF, 32'h12, 64'hFFFF_FFFF);
    req(0, 0, 1, 8'h0, 32'h24, 64'hFFFF_FFFF);
    req(0, 1, 0, 8'h0, 32'h24, 64'h0);
    idle_bus();

    // Same-cycle read and write to one word.
    req(0, 0, 1, 8'hF, 32'h20, 64'h1234_5678);
    req(0, 1, 1, 8'h3, 32'h20, 64'hFFFF_FFFF);
    req(0, 1, 0, 8'h0, 32'h20, 64'h0);
    idle_bus();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) idle_bus();
      else req(0, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), rand_addr0(),
               {32'h0, 32'($urandom)});
    end
    idle_bus();

    // 64-bit instance with a non-zero base.
    req(1, 1, 0, 8'h00, 32'h0FF8, 64'h0);
    req(1, 0, 1, 8'hFF, 32'h1008, 64'h0123_4567_89AB_CDEF);
    req(1, 1, 0, 8'h00, 32'h1008, 64'h0);
    req(1, 1, 0, 8'h00, 32'h100C, 64'h0);
    req(1, 1, 0, 8'h00, 32'h1080, 64'h0);
    req(1, 1, 1, 8'hF0, 32'h1078, 64'hFFEE_DDCC_BBAA_9988);
    idle_bus();
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 9) == 0) idle_bus();
      else req(1, 1'($urandom), 1'($urandom), 8'($urandom), rand_addr1(),
               {32'($urandom), 32'($urandom)});
    end
    idle_bus();

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_q0", 64'(q0.size()), 64'h0);
    chk("drain_q1", 64'(q1.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
